// File: rtl/vlc_rx_frame_ctrl.sv
// Receive-side VLC frame controller: sync hunt, length/payload/checksum
// deserialization, and a small payload FIFO with valid/ready output.
module vlc_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_WORD  = 8'hD5,
  parameter int         MAX_LEN    = 64,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       sof,
  output logic       eof,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic [TW-1:0] idle;
  logic [7:0]    bytes_left;
  logic [7:0]    checksum;
  logic          first_byte;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic [7:0]    cur_byte;
  logic          byte_done;
  logic          pop;
  logic          push_ok;
  logic          push;
  logic          abort;
  logic [1:0]    abort_code;
  logic          finish_ok;

  assign cur_byte   = {shreg[6:0], bit_in};
  assign byte_done  = bit_valid && (bitcnt == 3'd7);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid && byte_ready;
  assign push_ok    = (count < (AW+1)'(FIFO_DEPTH)) || pop;
  assign push       = (state == PAYLOAD) && byte_done && push_ok;

  assign byte_out = mem[rptr][7:0];
  assign eof      = mem[rptr][8];
  assign sof      = mem[rptr][9];

  // Decide whether the current cycle ends the frame, and how.
  always_comb begin
    abort      = 1'b0;
    abort_code = 2'd0;
    finish_ok  = 1'b0;
    if (state != HUNT) begin
      if (!bit_valid && idle == TW'(TIMEOUT - 1)) begin
        abort      = 1'b1;
        abort_code = 2'd2;
      end else if (byte_done) begin
        case (state)
          LEN: begin
            if (cur_byte == 8'd0 || cur_byte > 8'(MAX_LEN)) begin
              abort      = 1'b1;
              abort_code = 2'd0;
            end
          end
          PAYLOAD: begin
            if (!push_ok) begin
              abort      = 1'b1;
              abort_code = 2'd3;
            end
          end
          CHECK: begin
            if (cur_byte == checksum) begin
              finish_ok = 1'b1;
            end else begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      shreg      <= '0;
      bitcnt     <= '0;
      idle       <= '0;
      bytes_left <= '0;
      checksum   <= '0;
      first_byte <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      busy       <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (state == HUNT) begin
        if (bit_valid) begin
          shreg <= cur_byte;
          if (cur_byte == SYNC_WORD) begin
            state  <= LEN;
            busy   <= 1'b1;
            bitcnt <= '0;
            idle   <= '0;
          end
        end
      end else if (abort || finish_ok) begin
        // Clearing the shift register forces sync to be found on fresh bits.
        state     <= HUNT;
        busy      <= 1'b0;
        shreg     <= '0;
        bitcnt    <= '0;
        idle      <= '0;
        frame_ok  <= finish_ok;
        frame_err <= abort;
        if (abort) err_code <= abort_code;
      end else begin
        if (bit_valid) begin
          shreg  <= cur_byte;
          bitcnt <= bitcnt + 3'd1;
          idle   <= '0;
        end else begin
          idle <= idle + TW'(1);
        end
        if (byte_done) begin
          case (state)
            LEN: begin
              checksum   <= '0;
              bytes_left <= cur_byte;
              first_byte <= 1'b1;
              state      <= PAYLOAD;
            end
            PAYLOAD: begin
              checksum   <= checksum + cur_byte;
              bytes_left <= bytes_left - 8'd1;
              first_byte <= 1'b0;
              if (bytes_left == 8'd1) state <= CHECK;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Payload FIFO; a full FIFO still accepts a push when a pop frees a slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {first_byte, bytes_left == 8'd1, cur_byte};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

endmodule
